// File: rtl/posicion_sprites.sv
// posicion_sprites
// Sprite window matcher for a tile-based video pipeline. Each sprite window
// is described by a horizontal range in tile units and a vertical range in
// tile rows. The current beam position is compared against every enabled
// window. The winning window (lowest index) produces an image ROM address
// built from the sprite id, the tile-row offset inside the sprite and the
// pixel row inside the tile.
//
// Configuration is double buffered. Host writes go to a shadow copy, and the
// whole shadow copy is moved to the active copy on frame_start. Windows
// therefore never change in the middle of a frame.
//
// Pipeline:
//   stage 1 registers the beam position (Qh, tile row, pixel row, pix_en)
//   stage 2 compares against the active windows and registers the outputs
// The result appears two cycles after Qh/Qv/pix_en.

module posicion_sprites #(
    parameter int N_SPR = 4,   // number of sprite windows (1..8)
    parameter int HW    = 5,   // horizontal tile-coordinate width
    parameter int VW    = 10,  // vertical pixel-coordinate width
    parameter int ROW_W = 5,   // pixel-row bits per tile
    parameter int ID_W  = 4,   // image-id width
    parameter int HT_W  = 1    // tile-row-offset bits inside a sprite
) (
    input  logic                         reloj,
    input  logic                         resetM,
    input  logic [HW-1:0]                Qh,
    input  logic [VW-1:0]                Qv,
    input  logic                         pix_en,
    input  logic                         frame_start,
    input  logic                         cfg_we,
    input  logic [2:0]                   cfg_sel,
    input  logic [2:0]                   cfg_field,
    input  logic [9:0]                   cfg_data,
    output logic [ID_W+HT_W+ROW_W-1:0]   DIR_IM,
    output logic                         dir_valid,
    output logic                         hit,
    output logic [2:0]                   hit_idx
);

    // Address width and the width of a vertical coordinate in tile units.
    localparam int AW  = ID_W + HT_W + ROW_W;
    localparam int VTW = VW - ROW_W;

    // Configuration field codes carried on cfg_field.
    localparam logic [2:0] F_H_START = 3'd0;
    localparam logic [2:0] F_H_END   = 3'd1;
    localparam logic [2:0] F_V_START = 3'd2;
    localparam logic [2:0] F_V_END   = 3'd3;
    localparam logic [2:0] F_ID      = 3'd4;
    localparam logic [2:0] F_ENABLE  = 3'd5;

    // ------------------------------------------------------------------
    // Shadow registers. The host writes these at any time.
    // ------------------------------------------------------------------
    logic [HW-1:0]   sh_h_start [N_SPR];
    logic [HW-1:0]   sh_h_end   [N_SPR];
    logic [VTW-1:0]  sh_v_start [N_SPR];
    logic [VTW-1:0]  sh_v_end   [N_SPR];
    logic [ID_W-1:0] sh_id      [N_SPR];
    logic            sh_en      [N_SPR];

    // ------------------------------------------------------------------
    // Active registers. Only the stage-2 matcher reads these.
    // ------------------------------------------------------------------
    logic [HW-1:0]   ac_h_start [N_SPR];
    logic [HW-1:0]   ac_h_end   [N_SPR];
    logic [VTW-1:0]  ac_v_start [N_SPR];
    logic [VTW-1:0]  ac_v_end   [N_SPR];
    logic [ID_W-1:0] ac_id      [N_SPR];
    logic            ac_en      [N_SPR];

    // A write is accepted only for an existing sprite and a defined field.
    // Any other write is dropped completely.
    logic sel_ok;
    logic field_ok;
    logic wr_ok;

    assign sel_ok   = (32'(cfg_sel) < 32'(N_SPR));
    assign field_ok = (cfg_field <= F_ENABLE);
    assign wr_ok    = cfg_we && sel_ok && field_ok;

    // Shadow write port: store the LSBs of cfg_data in the selected field.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            for (int i = 0; i < N_SPR; i++) begin
                sh_h_start[i] <= '0;
                sh_h_end[i]   <= '0;
                sh_v_start[i] <= '0;
                sh_v_end[i]   <= '0;
                sh_id[i]      <= '0;
                sh_en[i]      <= 1'b0;
            end
        end else if (wr_ok) begin
            for (int i = 0; i < N_SPR; i++) begin
                if (cfg_sel == 3'(i)) begin
                    case (cfg_field)
                        F_H_START: sh_h_start[i] <= cfg_data[HW-1:0];
                        F_H_END:   sh_h_end[i]   <= cfg_data[HW-1:0];
                        F_V_START: sh_v_start[i] <= cfg_data[VTW-1:0];
                        F_V_END:   sh_v_end[i]   <= cfg_data[VTW-1:0];
                        F_ID:      sh_id[i]      <= cfg_data[ID_W-1:0];
                        F_ENABLE:  sh_en[i]      <= cfg_data[0];
                        default:   ;
                    endcase
                end
            end
        end
    end

    // Frame commit: copy all shadow state to active at frame_start. A write
    // in the same cycle is not seen here, because the copy samples the
    // shadow value from before that edge.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            for (int i = 0; i < N_SPR; i++) begin
                ac_h_start[i] <= '0;
                ac_h_end[i]   <= '0;
                ac_v_start[i] <= '0;
                ac_v_end[i]   <= '0;
                ac_id[i]      <= '0;
                ac_en[i]      <= 1'b0;
            end
        end else if (frame_start) begin
            for (int i = 0; i < N_SPR; i++) begin
                ac_h_start[i] <= sh_h_start[i];
                ac_h_end[i]   <= sh_h_end[i];
                ac_v_start[i] <= sh_v_start[i];
                ac_v_end[i]   <= sh_v_end[i];
                ac_id[i]      <= sh_id[i];
                ac_en[i]      <= sh_en[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: register the beam position. The vertical coordinate is split
    // into the tile row (vt) and the pixel row inside the tile (row).
    // ------------------------------------------------------------------
    logic [HW-1:0]    s1_qh;
    logic [VTW-1:0]   s1_vt;
    logic [ROW_W-1:0] s1_row;
    logic             s1_pix;

    // Stage-1 capture of the beam position.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            s1_qh  <= '0;
            s1_vt  <= '0;
            s1_row <= '0;
            s1_pix <= 1'b0;
        end else begin
            s1_qh  <= Qh;
            s1_vt  <= Qv[VW-1:ROW_W];
            s1_row <= Qv[ROW_W-1:0];
            s1_pix <= pix_en;
        end
    end

    // ------------------------------------------------------------------
    // Per-sprite window compare against the active copy. The windows are
    // half-open on both axes. A window whose end is at or below its start
    // therefore never matches, and no extra check is needed.
    // ------------------------------------------------------------------
    logic [N_SPR-1:0] match;
    logic [VTW-1:0]   offs [N_SPR];

    generate
        for (genvar gi = 0; gi < N_SPR; gi++) begin : g_win
            logic h_in;
            logic v_in;

            assign h_in = (ac_h_start[gi] <= s1_qh) && (s1_qh < ac_h_end[gi]);
            assign v_in = (ac_v_start[gi] <= s1_vt) && (s1_vt < ac_v_end[gi]);

            assign match[gi] = ac_en[gi] && h_in && v_in;

            // Tile-row offset inside the sprite. Only the low HT_W bits are
            // used, so a window taller than 2^HT_W tiles repeats its image.
            assign offs[gi] = s1_vt - ac_v_start[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Priority select: the lowest-index matching sprite wins.
    // ------------------------------------------------------------------
    logic          sel_hit;
    logic [2:0]    sel_idx;
    logic [AW-1:0] sel_addr;

    // Scan from the highest index down, so the lowest match is assigned last.
    always_comb begin
        sel_hit  = 1'b0;
        sel_idx  = 3'd0;
        sel_addr = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel_hit  = 1'b1;
                sel_idx  = 3'(i);
                sel_addr = {ac_id[i], offs[i][HT_W-1:0], s1_row};
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: registered outputs. dir_valid follows pix_en only. The
    // address fields are zero unless a valid pixel hit a window.
    // ------------------------------------------------------------------

    // Stage-2 output register.
    always_ff @(posedge reloj or posedge resetM) begin
        if (resetM) begin
            DIR_IM    <= '0;
            dir_valid <= 1'b0;
            hit       <= 1'b0;
            hit_idx   <= 3'd0;
        end else begin
            dir_valid <= s1_pix;
            if (s1_pix && sel_hit) begin
                DIR_IM  <= sel_addr;
                hit     <= 1'b1;
                hit_idx <= sel_idx;
            end else begin
                DIR_IM  <= '0;
                hit     <= 1'b0;
                hit_idx <= 3'd0;
            end
        end
    end

endmodule

// File: tb/tb_posicion_sprites.sv
// Directed testbench for posicion_sprites (default parameters).
// Each expected output value is computed by hand from the window setup.
module tb_posicion_sprites;

    logic       reloj = 1'b0;
    logic       resetM;
    logic [4:0] Qh;
    logic [9:0] Qv;
    logic       pix_en;
    logic       frame_start;
    logic       cfg_we;
    logic [2:0] cfg_sel;
    logic [2:0] cfg_field;
    logic [9:0] cfg_data;
    logic [9:0] DIR_IM;
    logic       dir_valid;
    logic       hit;
    logic [2:0] hit_idx;

    int n_pass  = 0;
    int n_total = 0;

    posicion_sprites dut (
        .reloj       (reloj),
        .resetM      (resetM),
        .Qh          (Qh),
        .Qv          (Qv),
        .pix_en      (pix_en),
        .frame_start (frame_start),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_field   (cfg_field),
        .cfg_data    (cfg_data),
        .DIR_IM      (DIR_IM),
        .dir_valid   (dir_valid),
        .hit         (hit),
        .hit_idx     (hit_idx)
    );

    always #5 reloj = ~reloj;

    // Wait for the next rising edge, then move 1 time unit past it.
    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    task automatic cfg(input logic [2:0] s, input logic [2:0] f, input logic [9:0] d);
        cfg_we    = 1'b1;
        cfg_sel   = s;
        cfg_field = f;
        cfg_data  = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic commit();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic sprite(input logic [2:0] s, input logic [9:0] hs, input logic [9:0] he,
                          input logic [9:0] vs, input logic [9:0] ve,
                          input logic [9:0] id, input logic [9:0] en);
        cfg(s, 3'd0, hs);
        cfg(s, 3'd1, he);
        cfg(s, 3'd2, vs);
        cfg(s, 3'd3, ve);
        cfg(s, 3'd4, id);
        cfg(s, 3'd5, en);
    endtask

    // Apply one beam position and wait the two-cycle latency.
    task automatic pixel(input logic [4:0] qh, input logic [9:0] qv, input logic pe);
        Qh     = qh;
        Qv     = qv;
        pix_en = pe;
        tick();
        tick();
    endtask

    task automatic expect_out(input string tag, input logic [9:0] e_dir, input logic e_val,
                              input logic e_hit, input logic [2:0] e_idx);
        $display("%s: DIR_IM=%h dir_valid=%b hit=%b hit_idx=%0d", tag, DIR_IM, dir_valid, hit, hit_idx);
        n_total++;
        assert (DIR_IM === e_dir) n_pass++;
        else $error("FAIL %s DIR_IM observed=%h expected=%h", tag, DIR_IM, e_dir);
        n_total++;
        assert (dir_valid === e_val) n_pass++;
        else $error("FAIL %s dir_valid observed=%b expected=%b", tag, dir_valid, e_val);
        n_total++;
        assert (hit === e_hit) n_pass++;
        else $error("FAIL %s hit observed=%b expected=%b", tag, hit, e_hit);
        n_total++;
        assert (hit_idx === e_idx) n_pass++;
        else $error("FAIL %s hit_idx observed=%0d expected=%0d", tag, hit_idx, e_idx);
    endtask

    initial begin
        resetM      = 1'b1;
        Qh          = '0;
        Qv          = '0;
        pix_en      = 1'b0;
        frame_start = 1'b0;
        cfg_we      = 1'b0;
        cfg_sel     = '0;
        cfg_field   = '0;
        cfg_data    = '0;
        repeat (2) tick();
        expect_out("reset", 10'h000, 1'b0, 1'b0, 3'd0);
        resetM = 1'b0;

        // a) basic hit and both half-open edges
        sprite(3'd0, 10'd4, 10'd5, 10'd3, 10'd4, 10'd3, 10'd1);
        commit();
        pixel(5'd4, 10'h06A, 1'b1);
        expect_out("a_hit", 10'h0CA, 1'b1, 1'b1, 3'd0);
        pixel(5'd5, 10'h06A, 1'b1);
        expect_out("a_h_end_edge", 10'h000, 1'b1, 1'b0, 3'd0);
        pixel(5'd4, 10'h08A, 1'b1);
        expect_out("a_v_end_edge", 10'h000, 1'b1, 1'b0, 3'd0);

        // b) overlapping windows: lowest index wins
        sprite(3'd1, 10'd10, 10'd12, 10'd6, 10'd8, 10'd1, 10'd1);
        sprite(3'd2, 10'd11, 10'd13, 10'd7, 10'd9, 10'd4, 10'd1);
        commit();
        pixel(5'd11, 10'h0E5, 1'b1);
        expect_out("b_prio1", 10'h065, 1'b1, 1'b1, 3'd1);
        cfg(3'd1, 3'd5, 10'd0);
        commit();
        pixel(5'd11, 10'h0E5, 1'b1);
        expect_out("b_prio2", 10'h105, 1'b1, 1'b1, 3'd2);

        // c) two-tile sprite: the tile-row offset selects the image half
        sprite(3'd3, 10'd20, 10'd22, 10'd12, 10'd14, 10'd9, 10'd1);
        commit();
        pixel(5'd20, 10'h1A3, 1'b1);
        expect_out("c_tall_off1", 10'h263, 1'b1, 1'b1, 3'd3);
        pixel(5'd21, 10'h180, 1'b1);
        expect_out("c_tall_off0", 10'h240, 1'b1, 1'b1, 3'd3);

        // d) shadow-only write, then a write in the same cycle as a commit
        cfg(3'd0, 3'd4, 10'd5);
        pixel(5'd4, 10'h06A, 1'b1);
        expect_out("d_shadow_only", 10'h0CA, 1'b1, 1'b1, 3'd0);
        cfg_we      = 1'b1;
        cfg_sel     = 3'd0;
        cfg_field   = 3'd4;
        cfg_data    = 10'h3F6;
        frame_start = 1'b1;
        tick();
        cfg_we      = 1'b0;
        frame_start = 1'b0;
        pixel(5'd4, 10'h06A, 1'b1);
        expect_out("d_coincident_old", 10'h14A, 1'b1, 1'b1, 3'd0);
        commit();
        pixel(5'd4, 10'h06A, 1'b1);
        expect_out("d_next_frame", 10'h18A, 1'b1, 1'b1, 3'd0);

        // e) empty window, out-of-range writes, pix_en low
        cfg(3'd3, 3'd1, 10'd20);
        commit();
        pixel(5'd20, 10'h1A3, 1'b1);
        expect_out("e_empty_win", 10'h000, 1'b1, 1'b0, 3'd0);
        cfg(3'd4, 3'd5, 10'd0);
        cfg(3'd4, 3'd4, 10'd0);
        cfg(3'd7, 3'd5, 10'd0);
        cfg(3'd0, 3'd6, 10'd0);
        cfg(3'd0, 3'd7, 10'd0);
        commit();
        pixel(5'd4, 10'h06A, 1'b1);
        expect_out("e_bad_writes", 10'h18A, 1'b1, 1'b1, 3'd0);
        pixel(5'd4, 10'h06A, 1'b0);
        expect_out("e_pix_off", 10'h000, 1'b0, 1'b0, 3'd0);

        // f) reset with hits in flight
        pixel(5'd4, 10'h06A, 1'b1);
        expect_out("f_before_rst", 10'h18A, 1'b1, 1'b1, 3'd0);
        resetM = 1'b1;
        #1;
        expect_out("f_rst_async", 10'h000, 1'b0, 1'b0, 3'd0);
        tick();
        resetM = 1'b0;
        tick();
        tick();
        expect_out("f_after_rel", 10'h000, 1'b1, 1'b0, 3'd0);
        commit();
        pixel(5'd4, 10'h06A, 1'b1);
        expect_out("f_commit_empty", 10'h000, 1'b1, 1'b0, 3'd0);
        sprite(3'd0, 10'd4, 10'd5, 10'd3, 10'd4, 10'd3, 10'd1);
        commit();
        pixel(5'd4, 10'h06A, 1'b1);
        expect_out("f_reconfig", 10'h0CA, 1'b1, 1'b1, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
